scan_cfg_loader: RTL and testbench

- Configuration-side driver for the fabric's serial SRAM scan chain.
- Accepts configuration words over a valid/ready stream, serialises them MSB-first onto scan_in, and drives scan_en for exactly CHAIN_LEN shift cycles.
- Asserts cfg_done when the chain is loaded.
- Sits between the bitstream source (off-chip interface or boot controller) and the head of the daisy-chained LUT/routing SRAM chain.

---
 rtl/scan_cfg_loader.sv | 178 +++++++++++++++++
 tb/tb_scan_cfg_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_cfg_loader.sv
// Serial scan-chain configuration loader: stream words in, shift CHAIN_LEN bits MSB-first.
// Optional CRC-8 check of the shifted bits when the CFG_CRC_EN macro is defined.
module scan_cfg_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              scan_in,
  output logic              scan_en,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              crc_err
);

  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  localparam int SH_W  = $clog2(WORD_W + 1);
  localparam int ACC_W = $clog2(CHAIN_LEN + 2 * WORD_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
`ifdef CFG_CRC_EN
  localparam logic [1:0] S_CHECK = 2'd3;
`endif

  logic [1:0]        r_state;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [WORD_W-1:0] r_sh;
  logic [SH_W-1:0]   r_sh_cnt;
  logic [WORD_W-1:0] r_hold;
  logic              r_hold_full;
  logic              r_scan_in;
  logic              r_scan_en;
  logic              r_busy;
  logic              r_done;

  logic              w_shift;
  logic              w_last;
  logic              w_sh_free;
  logic [ACC_W-1:0]  w_acc;
  logic              w_covered;
  logic              w_ready;
  logic              w_accept;

`ifdef CFG_CRC_EN
  logic [7:0]        r_crc;
  logic              r_crc_err;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`endif

  assign w_shift   = (r_state == S_LOAD) && (r_sh_cnt != '0);
  assign w_last    = w_shift && (r_bit_cnt == BIT_W'(CHAIN_LEN - 1));
  // Shift register is free for a new word if empty now or emptied by this edge's shift.
  assign w_sh_free = (r_sh_cnt == '0) || (w_shift && (r_sh_cnt == SH_W'(1)));
  assign w_acc     = ACC_W'(r_bit_cnt) + ACC_W'(r_sh_cnt)
                   + (r_hold_full ? ACC_W'(WORD_W) : '0);
  assign w_covered = (w_acc >= ACC_W'(CHAIN_LEN));

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_LOAD:  w_ready = !r_hold_full && !w_covered;
`ifdef CFG_CRC_EN
      S_CHECK: w_ready = 1'b1;
`endif
      default: w_ready = 1'b0;
    endcase
  end

  assign w_accept = in_valid && w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_sh        <= '0;
      r_sh_cnt    <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_scan_in   <= 1'b0;
      r_scan_en   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef CFG_CRC_EN
      r_crc       <= '0;
      r_crc_err   <= 1'b0;
`endif
    end else begin
      r_scan_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_bit_cnt   <= '0;
            r_sh_cnt    <= '0;
            r_hold_full <= 1'b0;
`ifdef CFG_CRC_EN
            r_crc       <= '0;
            r_crc_err   <= 1'b0;
`endif
          end else begin
            r_done <= (r_state == S_DONE);
            r_busy <= 1'b0;
          end
        end
        S_LOAD: begin
          // scan_in keeps its last value when starved; only scan_en drops.
          if (w_shift) begin
            r_scan_in <= r_sh[WORD_W-1];
            r_scan_en <= 1'b1;
            r_sh      <= r_sh << 1;
            r_sh_cnt  <= r_sh_cnt - SH_W'(1);
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
`ifdef CFG_CRC_EN
            r_crc     <= crc8_step(r_crc, r_sh[WORD_W-1]);
`endif
          end
          if (w_sh_free) begin
            if (r_hold_full) begin
              r_sh        <= r_hold;
              r_sh_cnt    <= SH_W'(WORD_W);
              r_hold_full <= 1'b0;
            end else if (w_accept) begin
              r_sh     <= in_data;
              r_sh_cnt <= SH_W'(WORD_W);
            end
          end else if (w_accept) begin
            r_hold      <= in_data;
            r_hold_full <= 1'b1;
          end
          // Unsent low bits of the final word are dropped here.
          if (w_last) begin
            r_sh_cnt    <= '0;
            r_hold_full <= 1'b0;
`ifdef CFG_CRC_EN
            r_state     <= S_CHECK;
`else
            r_state     <= S_DONE;
`endif
          end
        end
`ifdef CFG_CRC_EN
        S_CHECK: begin
          if (w_accept) begin
            r_crc_err <= (in_data[7:0] != r_crc);
            r_state   <= S_DONE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = w_ready;
  assign scan_in  = r_scan_in;
  assign scan_en  = r_scan_en;
  assign cfg_busy = r_busy;
  assign cfg_done = r_done;
`ifdef CFG_CRC_EN
  assign crc_err  = r_crc_err;
`else
  assign crc_err  = 1'b0;
`endif

endmodule

// File: tb/tb_scan_cfg_loader.sv
// Scoreboard bench for scan_cfg_loader: chain contents predicted from the word stream.
module tb_scan_cfg_loader;

`ifdef CFG_CRC_EN
  localparam int NI = 3;
  localparam bit CRC_ON = 1'b1;
`else
  localparam int NI = 2;
  localparam bit CRC_ON = 1'b0;
`endif
  localparam int CL [3] = '{16, 12, 8};

  typedef struct {
    int          k;
    logic [63:0] chain;
    int          min_span;
    int          max_span;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0] start_s, in_valid_s, in_ready_s, scan_in_s, scan_en_s, busy_s, done_s, crc_s;
  logic [7:0]    in_data_s [NI];

  int   n_tot = 0;
  int   n_bad = 0;
  exp_t sb[$];
  logic [7:0] ld_w [4];
  int         ld_gap [4];

  always #5 clk = ~clk;

  scan_cfg_loader #(.CHAIN_LEN(16), .WORD_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .in_valid(in_valid_s[0]),
    .in_data(in_data_s[0]), .in_ready(in_ready_s[0]), .scan_in(scan_in_s[0]),
    .scan_en(scan_en_s[0]), .cfg_busy(busy_s[0]), .cfg_done(done_s[0]), .crc_err(crc_s[0]));

  scan_cfg_loader #(.CHAIN_LEN(12), .WORD_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .in_valid(in_valid_s[1]),
    .in_data(in_data_s[1]), .in_ready(in_ready_s[1]), .scan_in(scan_in_s[1]),
    .scan_en(scan_en_s[1]), .cfg_busy(busy_s[1]), .cfg_done(done_s[1]), .crc_err(crc_s[1]));

`ifdef CFG_CRC_EN
  scan_cfg_loader #(.CHAIN_LEN(8), .WORD_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .in_valid(in_valid_s[2]),
    .in_data(in_data_s[2]), .in_ready(in_ready_s[2]), .scan_in(scan_in_s[2]),
    .scan_en(scan_en_s[2]), .cfg_busy(busy_s[2]), .cfg_done(done_s[2]), .crc_err(crc_s[2]));
`endif

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endfunction

  // Chain image: the first CL bits of the word stream, first bit deepest.
  function automatic logic [63:0] model_chain(input int cl, input int nw);
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < nw; i++) acc = (acc << 8) | {56'd0, ld_w[i]};
    return acc >> (nw * 8 - cl);
  endfunction

  function automatic logic [7:0] model_crc(input logic [63:0] chain, input int cl);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = cl - 1; i >= 0; i--) begin
      fb = c[7] ^ chain[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // Bounded wait until in_ready is high (sampled 1 time unit after an edge).
  task automatic wait_ready(input int k);
    int cnt;
    cnt = 0;
    while (!in_ready_s[k] && cnt < 200) begin
      @(posedge clk); #1;
      start_s[k] = 1'b0;
      cnt++;
    end
    if (cnt >= 200) begin
      n_tot++; n_bad++;
      $display("FAIL ready_timeout: inst %0d got in_ready=0 want 1", k);
    end
  endtask

  task automatic do_load(input int k, input int nw, input bit mid_start,
                         input int min_span, input int max_span, input bit bad);
    exp_t       e;
    logic [7:0] crc;
    logic [7:0] w;
    int         tot;
    int         cnt;
    bit         rdy_seen;
    e.k        = k;
    e.chain    = model_chain(CL[k], nw);
    e.min_span = min_span;
    e.max_span = max_span;
    e.err      = bad & CRC_ON;
    crc        = model_crc(e.chain, CL[k]);
    sb.push_back(e);
    tot = nw + (CRC_ON ? 1 : 0);
    @(posedge clk); #1;
    start_s[k] = 1'b1;
    for (int i = 0; i < tot; i++) begin
      w = (i < nw) ? ld_w[i] : (crc ^ {7'd0, bad});
      in_valid_s[k] = 1'b1;
      in_data_s[k]  = w;
      wait_ready(k);
      @(posedge clk); #1;
      start_s[k]    = mid_start && (i == 0);
      in_valid_s[k] = 1'b0;
      if (i < tot - 1) begin
        for (int g = 0; g < ld_gap[i]; g++) begin
          @(posedge clk); #1;
          start_s[k] = 1'b0;
        end
      end
    end
    cnt = 0;
    rdy_seen = 1'b0;
    while (!done_s[k] && cnt < 400) begin
      if (in_ready_s[k]) rdy_seen = 1'b1;
      start_s[k] = 1'b0;
      @(posedge clk); #1;
      cnt++;
    end
    start_s[k] = 1'b0;
    chk("ready_low_after_last_accept", rdy_seen, 1'b0);
    if (cnt >= 400) begin
      n_tot++; n_bad++;
      $display("FAIL done_timeout: inst %0d got cfg_done=0 want 1", k);
    end
    @(posedge clk); #1;
  endtask

  // Monitor: rebuild the chain from scan_in/scan_en and score each completed load.
  int          cyc = 0;
  logic [63:0] mch [NI];
  int          mn [NI];
  int          mfirst [NI];
  int          mlast [NI];
  logic        pdone [NI];

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        mch[k] = '0; mn[k] = 0; mfirst[k] = -1; mlast[k] = -1; pdone[k] = done_s[k];
      end else begin
        if (scan_en_s[k]) begin
          chk("busy_during_shift", busy_s[k], 1'b1);
          mch[k] = {mch[k][62:0], scan_in_s[k]};
          mn[k]++;
          if (mfirst[k] < 0) mfirst[k] = cyc;
          mlast[k] = cyc;
        end
        if (done_s[k] && !pdone[k]) begin
          if (sb.size() == 0) begin
            n_tot++; n_bad++;
            $display("FAIL unexpected_done: inst %0d got cfg_done=1 want no load pending", k);
          end else begin
            e = sb.pop_front();
            chk("sb_instance", k, e.k);
            chk("chain_contents", mch[k], e.chain);
            chk("shift_count", mn[k], CL[k]);
            chk("shift_span_in_range",
                (mlast[k] - mfirst[k] + 1 >= e.min_span) && (mlast[k] - mfirst[k] + 1 <= e.max_span), 1'b1);
`ifndef CFG_CRC_EN
            chk("done_one_cycle_after_last_shift", cyc - mlast[k], 1);
`endif
            chk("crc_err", crc_s[k], e.err);
            chk("busy_at_done", busy_s[k], 1'b0);
          end
          mch[k] = '0; mn[k] = 0; mfirst[k] = -1; mlast[k] = -1;
        end
        pdone[k] = done_s[k];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    rst_n = 1'b0;
    start_s = '0;
    in_valid_s = '0;
    for (int k = 0; k < NI; k++) in_data_s[k] = 8'h00;
    for (int i = 0; i < 4; i++) begin ld_w[i] = 8'h00; ld_gap[i] = 0; end
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_in_ready", in_ready_s[k], 1'b0);
      chk("rst_scan_in", scan_in_s[k], 1'b0);
      chk("rst_scan_en", scan_en_s[k], 1'b0);
      chk("rst_cfg_busy", busy_s[k], 1'b0);
      chk("rst_cfg_done", done_s[k], 1'b0);
      chk("rst_crc_err", crc_s[k], 1'b0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back words, then the same pair with a long gap forcing a bubble.
    ld_w[0] = 8'hA5; ld_w[1] = 8'hC3;
    do_load(0, 2, 1'b0, 16, 16, 1'b0);
    ld_gap[0] = 11;
    do_load(0, 2, 1'b0, 19, 100000, 1'b0);
    ld_gap[0] = 0;

    // Chain length not a multiple of the word width.
    ld_w[0] = 8'hFF; ld_w[1] = 8'h0F;
    do_load(1, 2, 1'b0, 12, 12, 1'b0);

    // Reset mid-load after five shifts.
    @(posedge clk); #1;
    start_s[0] = 1'b1;
    in_valid_s[0] = 1'b1;
    in_data_s[0] = 8'hA5;
    wait_ready(0);
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    in_valid_s[0] = 1'b0;
    n = 0; cnt = 0;
    while (n < 5 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
      if (scan_en_s[0]) n++;
    end
    chk("shifts_before_reset", n, 5);
    rst_n = 1'b0;
    #1;
    chk("async_rst_scan_en", scan_en_s[0], 1'b0);
    chk("async_rst_cfg_busy", busy_s[0], 1'b0);
    chk("async_rst_in_ready", in_ready_s[0], 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ld_w[0] = 8'hA5; ld_w[1] = 8'hC3;
    do_load(0, 2, 1'b0, 16, 16, 1'b0);

    // start pulsed during LOAD must be ignored.
    do_load(0, 2, 1'b1, 16, 16, 1'b0);

    // Randomized words and inter-word gaps on both chain lengths.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) begin
          ld_w[i]   = 8'($urandom);
          ld_gap[i] = $urandom_range(0, 12);
        end
        do_load(k, (CL[k] + 7) / 8, 1'b0, CL[k], 100000, 1'($urandom_range(0, 1)));
      end
    end

`ifdef CFG_CRC_EN
    ld_w[0] = 8'h01; ld_gap[0] = 0;
    do_load(2, 1, 1'b0, 8, 8, 1'b0);
    do_load(2, 1, 1'b0, 8, 8, 1'b1);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
